// File: rtl/pool_sequencer_pkg.sv
// rtl/pool_sequencer_pkg.sv - shared FSM encoding and pooling constants for pool_sequencer
`ifndef MAX_BITS_POOL
`define MAX_BITS_POOL 3
`endif

package pool_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [`MAX_BITS_POOL-1:0] KS_1 = `MAX_BITS_POOL'(1);
    localparam logic [`MAX_BITS_POOL-1:0] KS_2 = `MAX_BITS_POOL'(2);
    localparam logic [`MAX_BITS_POOL-1:0] KS_4 = `MAX_BITS_POOL'(4);

    // Register stages inside the pool unit between data-available and out_data.
    localparam int POOL_WR_DELAY = 1;

    function automatic logic kernel_legal(input logic [`MAX_BITS_POOL-1:0] ks);
        return (ks == KS_1) || (ks == KS_2) || (ks == KS_4);
    endfunction

endpackage

// File: rtl/pool_seq_wr_tracker.sv
// rtl/pool_seq_wr_tracker.sv - aligns write strobes to pool output and counts written vectors
module pool_seq_wr_tracker
    import pool_sequencer_pkg::*;
#(
    parameter int AWIDTH    = 10,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 busy_i,
    input  logic                 pool_mode_i,
    input  logic [CNT_WIDTH-1:0] num_vectors_i,
    input  logic [AWIDTH-1:0]    dst_base_i,
    input  logic                 rd_data_valid_i,
    output logic                 wr_en_o,
    output logic [AWIDTH-1:0]    wr_addr_o,
    output logic [CNT_WIDTH-1:0] written_next_o
);

    logic [POOL_WR_DELAY-1:0] dly_q, dly_d;
    logic [CNT_WIDTH-1:0]     written_q, written_d, inflight;
    logic                     accept;

    // Accept a returning vector only while busy and while writes (done plus pending) are short of the target.
    always_comb begin
        inflight  = written_q + CNT_WIDTH'($countones(dly_q));
        accept    = busy_i && rd_data_valid_i && (inflight != num_vectors_i);
        dly_d     = POOL_WR_DELAY'({dly_q, accept && pool_mode_i});
        wr_en_o   = pool_mode_i ? dly_q[POOL_WR_DELAY-1] : accept;
        written_d = wr_en_o ? written_q + CNT_WIDTH'(1) : written_q;
        wr_addr_o = wr_en_o ? dst_base_i + AWIDTH'(written_q) : '0;
        written_next_o = written_d;
    end

    // Delay line and written counter; a new run clears any stale state.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            dly_q     <= '0;
            written_q <= '0;
        end else begin
            dly_q     <= dly_d;
            written_q <= written_d;
        end
    end

endmodule

// File: rtl/pool_sequencer.sv
// rtl/pool_sequencer.sv - pool stage read/write sequencer; optional perf counters via POOL_SEQ_PERF_EN
`ifndef MAX_BITS_POOL
`define MAX_BITS_POOL 3
`endif

module pool_sequencer
    import pool_sequencer_pkg::*;
#(
    parameter int AWIDTH    = 10,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      enable_pool,
    input  logic [`MAX_BITS_POOL-1:0] kernel_size,
    input  logic [CNT_WIDTH-1:0]      num_vectors,
    input  logic [AWIDTH-1:0]         src_base_addr,
    input  logic [AWIDTH-1:0]         dst_base_addr,
    input  logic                      stall,
    output logic                      rd_en,
    output logic [AWIDTH-1:0]         rd_addr,
    input  logic                      rd_data_valid,
    output logic                      pool_enable,
    output logic [`MAX_BITS_POOL-1:0] pool_kernel_size,
    output logic                      pool_in_data_available,
    output logic                      wr_en,
    output logic [AWIDTH-1:0]         wr_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      error
`ifdef POOL_SEQ_PERF_EN
    ,
    output logic [31:0]               perf_cycles,
    output logic [31:0]               perf_stall_cycles
`endif
);

    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      issued_q, issued_d, num_q, written_d;
    logic [AWIDTH-1:0]         src_q, dst_q;
    logic                      pool_en_q, error_q, error_d, start_accept;
    logic [`MAX_BITS_POOL-1:0] ks_q;

    assign start_accept = (state_q == ST_IDLE) && start;
    assign busy         = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign pool_enable  = busy && pool_en_q;
    assign pool_kernel_size       = busy ? ks_q : '0;
    assign pool_in_data_available = busy && rd_data_valid;
    assign error        = error_q;

    pool_seq_wr_tracker #(.AWIDTH(AWIDTH), .CNT_WIDTH(CNT_WIDTH)) u_wr_tracker (
        .clk             (clk),
        .reset           (reset),
        .clr_i           (start_accept),
        .busy_i          (busy),
        .pool_mode_i     (pool_en_q),
        .num_vectors_i   (num_q),
        .dst_base_i      (dst_q),
        .rd_data_valid_i (rd_data_valid),
        .wr_en_o         (wr_en),
        .wr_addr_o       (wr_addr),
        .written_next_o  (written_d)
    );

    // Next-state, read issue and completion; finishing early skips DRAIN when all writes already landed.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        error_d  = error_q;
        rd_en    = 1'b0;
        rd_addr  = '0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    issued_d = '0;
                    error_d  = 1'b0;
                    if (enable_pool && !kernel_legal(kernel_size)) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (num_vectors == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    rd_en    = 1'b1;
                    rd_addr  = src_q + AWIDTH'(issued_q);
                    issued_d = issued_q + CNT_WIDTH'(1);
                    if (issued_d == num_q) begin
                        state_d = (written_d == num_q) ? ST_DONE : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (written_d == num_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, issue counter, error flag and configuration latched on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            issued_q  <= '0;
            error_q   <= 1'b0;
            num_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            pool_en_q <= 1'b0;
            ks_q      <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            error_q  <= error_d;
            if (start_accept) begin
                num_q     <= num_vectors;
                src_q     <= src_base_addr;
                dst_q     <= dst_base_addr;
                pool_en_q <= enable_pool;
                ks_q      <= kernel_size;
            end
        end
    end

`ifdef POOL_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_stall_q;

    assign perf_cycles       = perf_cycles_q;
    assign perf_stall_cycles = perf_stall_q;

    // Saturating busy-cycle and stalled-issue-cycle counters, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy && (perf_cycles_q != '1)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if ((state_q == ST_ISSUE) && stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pool_sequencer.sv
// tb/tb_pool_sequencer.sv - directed self-checking bench for pool_sequencer
`ifndef MAX_BITS_POOL
`define MAX_BITS_POOL 3
`endif

module tb_pool_sequencer;

    logic                      clk;
    logic                      reset;
    logic                      start;
    logic                      enable_pool;
    logic [`MAX_BITS_POOL-1:0] kernel_size;
    logic [15:0]               num_vectors;
    logic [9:0]                src_base_addr;
    logic [9:0]                dst_base_addr;
    logic                      stall;
    logic                      rd_en;
    logic [9:0]                rd_addr;
    logic                      rd_data_valid;
    logic                      pool_enable;
    logic [`MAX_BITS_POOL-1:0] pool_kernel_size;
    logic                      pool_in_data_available;
    logic                      wr_en;
    logic [9:0]                wr_addr;
    logic                      busy;
    logic                      done;
    logic                      error;
`ifdef POOL_SEQ_PERF_EN
    logic [31:0]               perf_cycles;
    logic [31:0]               perf_stall_cycles;
`endif

    pool_sequencer #(.AWIDTH(10), .CNT_WIDTH(16)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .enable_pool            (enable_pool),
        .kernel_size            (kernel_size),
        .num_vectors            (num_vectors),
        .src_base_addr          (src_base_addr),
        .dst_base_addr          (dst_base_addr),
        .stall                  (stall),
        .rd_en                  (rd_en),
        .rd_addr                (rd_addr),
        .rd_data_valid          (rd_data_valid),
        .pool_enable            (pool_enable),
        .pool_kernel_size       (pool_kernel_size),
        .pool_in_data_available (pool_in_data_available),
        .wr_en                  (wr_en),
        .wr_addr                (wr_addr),
        .busy                   (busy),
        .done                   (done),
        .error                  (error)
`ifdef POOL_SEQ_PERF_EN
        ,
        .perf_cycles            (perf_cycles),
        .perf_stall_cycles      (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rd_en_v, wr_en_v, done_v, busy_v, pe_v, pida_v, err_v;
    logic [2:0]  pks_a [32];
    logic [63:0] all_a [32];
    logic [9:0]  rd_q [$];
    logic [9:0]  wr_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One input set per cycle at the falling edge; read data returns one cycle after rd_en.
    task automatic run(input int n, input logic [31:0] start_m, input logic [31:0] stall_m,
                       input logic [31:0] reset_m);
        logic prev_rd;
        prev_rd = 1'b0;
        rd_en_v = '0; wr_en_v = '0; done_v = '0; busy_v = '0;
        pe_v = '0; pida_v = '0; err_v = '0;
        rd_q.delete(); wr_q.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start         = start_m[c];
            stall         = stall_m[c];
            reset         = reset_m[c];
            rd_data_valid = prev_rd;
            #1;
            rd_en_v[c] = rd_en;
            wr_en_v[c] = wr_en;
            done_v[c]  = done;
            busy_v[c]  = busy;
            pe_v[c]    = pool_enable;
            pida_v[c]  = pool_in_data_available;
            err_v[c]   = error;
            pks_a[c]   = pool_kernel_size;
            all_a[c]   = {34'd0, rd_en, wr_en, busy, done, error, pool_enable,
                          pool_in_data_available, pool_kernel_size, rd_addr, wr_addr};
            if (rd_en) rd_q.push_back(rd_addr);
            if (wr_en) wr_q.push_back(wr_addr);
            prev_rd = rd_en;
        end
        start = 1'b0; stall = 1'b0; reset = 1'b0; rd_data_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; rd_data_valid = 1'b0;
        enable_pool = 1'b1; kernel_size = 3'd2; num_vectors = 16'd0;
        src_base_addr = '0; dst_base_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {rd_en, wr_en, busy, done, error, pool_enable,
            pool_in_data_available, pool_kernel_size, rd_addr, wr_addr}, 64'd0);
        reset = 1'b0;

        // Pooled: N=4, k=2, src 0x10, dst 0x40
        enable_pool = 1'b1; kernel_size = 3'd2; num_vectors = 16'd4;
        src_base_addr = 10'h010; dst_base_addr = 10'h040;
        run(10, 32'h1, 32'h0, 32'h0);
        chk("pool_rd_en", rd_en_v, 32'h0000_001E);
        chk("pool_wr_en", wr_en_v, 32'h0000_0078);
        chk("pool_done", done_v, 32'h0000_0080);
        chk("pool_busy", busy_v, 32'h0000_007E);
        chk("pool_enable", pe_v, 32'h0000_007E);
        chk("pool_data_avail", pida_v, 32'h0000_003C);
        chk("pool_ksize", pks_a[2], 3'd2);
        chk("pool_error", err_v, 32'h0);
        chk("pool_rd_count", rd_q.size(), 4);
        chk("pool_wr_count", wr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pool_rd_addr%0d", i), rd_q[i], 10'h010 + 10'(i));
            chk($sformatf("pool_wr_addr%0d", i), wr_q[i], 10'h040 + 10'(i));
        end

        // Bypass: N=3
        enable_pool = 1'b0; num_vectors = 16'd3;
        src_base_addr = 10'h020; dst_base_addr = 10'h050;
        run(8, 32'h1, 32'h0, 32'h0);
        chk("byp_rd_en", rd_en_v, 32'h0000_000E);
        chk("byp_wr_en", wr_en_v, 32'h0000_001C);
        chk("byp_done", done_v, 32'h0000_0020);
        chk("byp_pool_enable", pe_v, 32'h0);
        chk("byp_busy", busy_v, 32'h0000_001E);
        chk("byp_wr_count", wr_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("byp_wr_addr%0d", i), wr_q[i], 10'h050 + 10'(i));

        // Stall in cycles 2-3
        enable_pool = 1'b1; kernel_size = 3'd4; num_vectors = 16'd4;
        src_base_addr = 10'h080; dst_base_addr = 10'h000;
        run(12, 32'h1, 32'h0000_000C, 32'h0);
        chk("stall_rd_en", rd_en_v, 32'h0000_0072);
        chk("stall_wr_en", wr_en_v, 32'h0000_01C8);
        chk("stall_done", done_v, 32'h0000_0200);
        chk("stall_wr_count", wr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_rd_addr%0d", i), rd_q[i], 10'h080 + 10'(i));
            chk($sformatf("stall_wr_addr%0d", i), wr_q[i], 10'(i));
        end

        // Illegal kernel, then a legal start clears error
        kernel_size = 3'd3; num_vectors = 16'd4;
        run(4, 32'h1, 32'h0, 32'h0);
        chk("ill_rd_en", rd_en_v, 32'h0);
        chk("ill_done", done_v, 32'h2);
        chk("ill_error", err_v, 32'hE);
        kernel_size = 3'd1; num_vectors = 16'd1;
        src_base_addr = 10'h000; dst_base_addr = 10'h000;
        run(6, 32'h1, 32'h0, 32'h0);
        chk("clr_error", err_v, 32'h1);
        chk("clr_done", done_v, 32'h10);
        chk("clr_wr_en", wr_en_v, 32'h8);

        // Zero vectors
        kernel_size = 3'd2; num_vectors = 16'd0;
        run(4, 32'h1, 32'h0, 32'h0);
        chk("zero_done", done_v, 32'h2);
        chk("zero_rd_en", rd_en_v, 32'h0);
        chk("zero_busy", busy_v, 32'h0);

        // Address wrap, bypass
        enable_pool = 1'b0; num_vectors = 16'd4;
        src_base_addr = 10'h3FE; dst_base_addr = 10'h3FF;
        run(8, 32'h1, 32'h0, 32'h0);
        chk("wrap_rd_count", rd_q.size(), 4);
        chk("wrap_rd_addr0", rd_q[0], 10'h3FE);
        chk("wrap_rd_addr1", rd_q[1], 10'h3FF);
        chk("wrap_rd_addr2", rd_q[2], 10'h000);
        chk("wrap_rd_addr3", rd_q[3], 10'h001);
        chk("wrap_wr_addr1", wr_q[1], 10'h000);
        chk("wrap_wr_addr3", wr_q[3], 10'h002);
        chk("wrap_done", done_v, 32'h40);

        // Reset mid-run with an ignored start in cycle 2
        enable_pool = 1'b1; kernel_size = 3'd2; num_vectors = 16'd8;
        src_base_addr = 10'h100; dst_base_addr = 10'h200;
        run(12, 32'h5, 32'h0, 32'h8);
        chk("rst_rd_en", rd_en_v, 32'h0000_000E);
        chk("rst_rd_addr2", rd_q[2], 10'h102);
        chk("rst_wr_en", wr_en_v, 32'h0000_0008);
        chk("rst_all_zero", all_a[4], 64'd0);
        chk("rst_no_done", done_v, 32'h0);

        // Start coincident with reset is dropped
        num_vectors = 16'd2;
        run(4, 32'h1, 32'h0, 32'h1);
        chk("rststart_rd_en", rd_en_v, 32'h0);
        chk("rststart_busy", busy_v, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
